// File: rtl/calc_nport_arb.sv
// Multi-port add/sub/shift engine: per-port two-cycle request capture, one shared
// ALU behind a fixed-priority or round-robin arbiter, results returned per port.
module calc_nport_arb #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 32,
   parameter int ARB_MODE  = 0
) (
   input  logic                        c_clk,
   input  logic                        reset,
   input  logic [4*NUM_PORTS-1:0]      req_cmd_in,
   input  logic [DATA_W*NUM_PORTS-1:0] req_data_in,
   output logic [2*NUM_PORTS-1:0]      out_resp,
   output logic [DATA_W*NUM_PORTS-1:0] out_data,
   output logic [NUM_PORTS-1:0]        port_busy
);

   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int SH_W  = $clog2(DATA_W);

   localparam logic [3:0] CMD_NONE = 4'b0000;
   localparam logic [3:0] CMD_ADD  = 4'b0001;
   localparam logic [3:0] CMD_SUB  = 4'b0010;
   localparam logic [3:0] CMD_SHL  = 4'b0101;
   localparam logic [3:0] CMD_SHR  = 4'b0110;

   localparam logic [1:0] RESP_OK     = 2'b01;
   localparam logic [1:0] RESP_IN_ERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OP2  = 2'd1,
      ST_WAIT = 2'd2,
      ST_EXEC = 2'd3
   } port_state_e;

   // Per-port request capture
   port_state_e       state_q [NUM_PORTS];
   port_state_e       state_d [NUM_PORTS];
   logic [3:0]        cmd_q   [NUM_PORTS];
   logic [3:0]        cmd_d   [NUM_PORTS];
   logic [DATA_W-1:0] op1_q   [NUM_PORTS];
   logic [DATA_W-1:0] op1_d   [NUM_PORTS];
   logic [DATA_W-1:0] op2_q   [NUM_PORTS];
   logic [DATA_W-1:0] op2_d   [NUM_PORTS];

   // Arbiter
   logic [NUM_PORTS-1:0] wait_req;
   logic                 gnt_valid;
   logic [PTR_W-1:0]     gnt_idx;
   logic [PTR_W-1:0]     cand_idx;
   logic [PTR_W-1:0]     rr_ptr_q;
   logic [PTR_W-1:0]     rr_ptr_d;
   int                   cand;
   int                   nxt;

   // Execute stage
   logic              exec_valid_q, exec_valid_d;
   logic [PTR_W-1:0]  exec_port_q,  exec_port_d;
   logic [3:0]        exec_cmd_q,   exec_cmd_d;
   logic [DATA_W-1:0] exec_op1_q,   exec_op1_d;
   logic [DATA_W-1:0] exec_op2_q,   exec_op2_d;

   logic [DATA_W:0]   add_full;
   logic [1:0]        alu_resp;
   logic [DATA_W-1:0] alu_data;

   // Registered responses
   logic [2*NUM_PORTS-1:0]      out_resp_q, out_resp_d;
   logic [DATA_W*NUM_PORTS-1:0] out_data_q, out_data_d;

   always_comb begin
      wait_req  = '0;
      port_busy = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         wait_req[p]  = (state_q[p] == ST_WAIT);
         port_busy[p] = (state_q[p] != ST_IDLE);
      end
   end

   // Search order starts at port 0 in fixed mode, at the pointer in round-robin mode.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand     = (ARB_MODE == 1) ? (int'(rr_ptr_q) + i) % NUM_PORTS : i;
         cand_idx = cand[PTR_W-1:0];
         if (!gnt_valid && wait_req[cand_idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      nxt      = 0;
      if ((ARB_MODE == 1) && gnt_valid) begin
         nxt      = (int'(gnt_idx) + 1) % NUM_PORTS;
         rr_ptr_d = nxt[PTR_W-1:0];
      end
   end

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         state_d[p] = state_q[p];
         cmd_d[p]   = cmd_q[p];
         op1_d[p]   = op1_q[p];
         op2_d[p]   = op2_q[p];
         case (state_q[p])
            ST_IDLE: begin
               if (req_cmd_in[4*p +: 4] != CMD_NONE) begin
                  cmd_d[p]   = req_cmd_in[4*p +: 4];
                  op1_d[p]   = req_data_in[DATA_W*p +: DATA_W];
                  state_d[p] = ST_OP2;
               end
            end
            ST_OP2: begin
               op2_d[p]   = req_data_in[DATA_W*p +: DATA_W];
               state_d[p] = ST_WAIT;
            end
            ST_WAIT: begin
               if (gnt_valid && (int'(gnt_idx) == p)) state_d[p] = ST_EXEC;
            end
            ST_EXEC: begin
               if (exec_valid_q && (int'(exec_port_q) == p)) state_d[p] = ST_IDLE;
            end
            default: state_d[p] = ST_IDLE;
         endcase
      end
   end

   // Operands are copied at grant so the port's own registers stay untouched.
   always_comb begin
      exec_valid_d = gnt_valid;
      exec_port_d  = gnt_idx;
      exec_cmd_d   = cmd_q[gnt_idx];
      exec_op1_d   = op1_q[gnt_idx];
      exec_op2_d   = op2_q[gnt_idx];
   end

   always_comb begin
      add_full = {1'b0, exec_op1_q} + {1'b0, exec_op2_q};
      alu_resp = RESP_OK;
      alu_data = '0;
      case (exec_cmd_q)
         CMD_ADD: begin
            if (add_full[DATA_W]) alu_resp = RESP_IN_ERR;
            else                  alu_data = add_full[DATA_W-1:0];
         end
         CMD_SUB: begin
            if (exec_op2_q > exec_op1_q) alu_resp = RESP_IN_ERR;
            else                         alu_data = exec_op1_q - exec_op2_q;
         end
         CMD_SHL: alu_data = exec_op1_q << exec_op2_q[SH_W-1:0];
         CMD_SHR: alu_data = exec_op1_q >> exec_op2_q[SH_W-1:0];
         default: alu_resp = RESP_IN_ERR;
      endcase
   end

   always_comb begin
      out_resp_d = '0;
      out_data_d = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (exec_valid_q && (int'(exec_port_q) == p)) begin
            out_resp_d[2*p +: 2]           = alu_resp;
            out_data_d[DATA_W*p +: DATA_W] = alu_data;
         end
      end
   end

   always_ff @(posedge c_clk) begin
      if (!reset) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            state_q[p] <= ST_IDLE;
            cmd_q[p]   <= '0;
            op1_q[p]   <= '0;
            op2_q[p]   <= '0;
         end
         rr_ptr_q     <= '0;
         exec_valid_q <= 1'b0;
         exec_port_q  <= '0;
         exec_cmd_q   <= '0;
         exec_op1_q   <= '0;
         exec_op2_q   <= '0;
         out_resp_q   <= '0;
         out_data_q   <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            state_q[p] <= state_d[p];
            cmd_q[p]   <= cmd_d[p];
            op1_q[p]   <= op1_d[p];
            op2_q[p]   <= op2_d[p];
         end
         rr_ptr_q     <= rr_ptr_d;
         exec_valid_q <= exec_valid_d;
         exec_port_q  <= exec_port_d;
         exec_cmd_q   <= exec_cmd_d;
         exec_op1_q   <= exec_op1_d;
         exec_op2_q   <= exec_op2_d;
         out_resp_q   <= out_resp_d;
         out_data_q   <= out_data_d;
      end
   end

   assign out_resp = out_resp_q;
   assign out_data = out_data_q;

endmodule

// File: tb/tb_calc_nport_arb.sv
// Bench for calc_nport_arb: one fixed-priority and one round-robin instance side by side,
// expected responses queued at issue time and matched by a negedge monitor.
module tb_calc_nport_arb;

   localparam int NP = 4;
   localparam int DW = 32;
   localparam int EW = 54; // {dut, port[2:0], cycle[15:0], resp[1:0], data[31:0]}

   logic c_clk = 1'b0;
   logic reset = 1'b0;

   logic [4*NP-1:0]  cmd0  = '0;
   logic [4*NP-1:0]  cmd1  = '0;
   logic [DW*NP-1:0] data0 = '0;
   logic [DW*NP-1:0] data1 = '0;
   logic [2*NP-1:0]  resp0, resp1;
   logic [DW*NP-1:0] odata0, odata1;
   logic [NP-1:0]    busy0, busy1;

   int cyc        = 0;
   int compared   = 0;
   int mismatched = 0;

   logic [EW-1:0] exp_q[$];

   // Level checks requested by the stimulus, performed by the monitor.
   int          chk_mode  = 0;
   string       chk_name  = "";
   logic [NP-1:0] chk_busy0 = '0;
   logic [NP-1:0] chk_busy1 = '0;
   bit          final_chk  = 1'b0;
   bit          final_seen = 1'b0;

   calc_nport_arb #(.NUM_PORTS(NP), .DATA_W(DW), .ARB_MODE(0)) dut0 (
      .c_clk      (c_clk),
      .reset      (reset),
      .req_cmd_in (cmd0),
      .req_data_in(data0),
      .out_resp   (resp0),
      .out_data   (odata0),
      .port_busy  (busy0)
   );

   calc_nport_arb #(.NUM_PORTS(NP), .DATA_W(DW), .ARB_MODE(1)) dut1 (
      .c_clk      (c_clk),
      .reset      (reset),
      .req_cmd_in (cmd1),
      .req_data_in(data1),
      .out_resp   (resp1),
      .out_data   (odata1),
      .port_busy  (busy1)
   );

   // Clock and cycle counter
   always #5 c_clk = ~c_clk;
   always @(posedge c_clk) cyc <= cyc + 1;

   // Driver tasks
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge c_clk);
         #1;
         chk_mode = 0;
      end
   endtask

   task automatic drive(input int d, input int p, input logic [3:0] c, input logic [31:0] v);
      if (d == 0) begin
         cmd0[4*p +: 4]   = c;
         data0[DW*p +: DW] = v;
      end else begin
         cmd1[4*p +: 4]   = c;
         data1[DW*p +: DW] = v;
      end
   endtask

   task automatic expect_resp(input int d, input int p, input int at,
                              input logic [1:0] r, input logic [31:0] v);
      logic [EW-1:0] e;
      e = {d[0], p[2:0], at[15:0], r, v};
      exp_q.push_back(e);
   endtask

   task automatic set_chk(input int mode, input string nm,
                          input logic [NP-1:0] b0, input logic [NP-1:0] b1);
      chk_name  = nm;
      chk_busy0 = b0;
      chk_busy1 = b1;
      chk_mode  = mode;
   endtask

   // One request on one port, response expected exactly 4 cycles after cmd.
   task automatic req1(input int d, input int p, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] r, input logic [31:0] v, input int tail);
      logic [NP-1:0] own;
      own = '0;
      own[p] = 1'b1;
      expect_resp(d, p, cyc + 4, r, v);
      drive(d, p, c, a);
      tick(1);
      if (d == 0) set_chk(1, "busy_single", own, '0);
      else        set_chk(1, "busy_single", '0, own);
      drive(d, p, 4'b0000, b);
      tick(1);
      drive(d, p, 4'b0000, 32'h0);
      tick(tail);
   endtask

   // Scoreboard
   task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s cyc=%0d: got %h, need %h", nm, cyc, act, req);
      end
   endtask

   task automatic got(input int d, input int p, input logic [1:0] r, input logic [31:0] v);
      int idx;
      logic [EW-1:0] e;
      idx = -1;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (idx < 0 && exp_q[i][53] == d[0] && int'(exp_q[i][52:50]) == p) idx = i;
      end
      compared++;
      if (idx < 0) begin
         mismatched++;
         $display("FAIL unexpected_resp dut%0d port%0d cyc=%0d: got resp=%0h data=%h, need no response",
                  d, p, cyc, r, v);
      end else begin
         e = exp_q[idx];
         exp_q.delete(idx);
         if (r !== e[33:32] || v !== e[31:0] || cyc != int'(e[49:34])) begin
            mismatched++;
            $display("FAIL resp dut%0d port%0d: got resp=%0h data=%h cyc=%0d, need resp=%0h data=%h cyc=%0d",
                     d, p, r, v, cyc, e[33:32], e[31:0], int'(e[49:34]));
         end
      end
   endtask

   // Monitor
   always @(negedge c_clk) begin
      for (int p = 0; p < NP; p++) begin
         if (resp0[2*p +: 2] != 2'b00) got(0, p, resp0[2*p +: 2], odata0[DW*p +: DW]);
         if (resp1[2*p +: 2] != 2'b00) got(1, p, resp1[2*p +: 2], odata1[DW*p +: DW]);
      end
      if (chk_mode != 0) begin
         cmp({chk_name, "_busy0"}, 128'(busy0), 128'(chk_busy0));
         cmp({chk_name, "_busy1"}, 128'(busy1), 128'(chk_busy1));
         if (chk_mode == 2) begin
            cmp({chk_name, "_resp0"}, 128'(resp0), 128'h0);
            cmp({chk_name, "_resp1"}, 128'(resp1), 128'h0);
            cmp({chk_name, "_data0"}, 128'(odata0), 128'h0);
            cmp({chk_name, "_data1"}, 128'(odata1), 128'h0);
         end
      end
      if (final_chk && !final_seen) begin
         final_seen = 1'b1;
         cmp("pending_expectations", 128'(exp_q.size()), 128'h0);
         while (exp_q.size() > 0) begin
            $display("FAIL missing_resp dut%0d port%0d: got nothing, need resp=%0h data=%h at cyc=%0d",
                     exp_q[0][53], exp_q[0][52:50], exp_q[0][33:32], exp_q[0][31:0],
                     int'(exp_q[0][49:34]));
            exp_q.delete(0);
         end
      end
   end

   // Stimulus
   initial begin : stimulus
      int t0;
      int rr_off [NP];
      rr_off = '{6, 7, 4, 5};

      reset = 1'b0;
      tick(3);
      set_chk(2, "reset_state", '0, '0);
      reset = 1'b1;
      tick(2);

      // Same add on every port of the fixed-priority instance
      for (int p = 0; p < NP; p++)
         req1(0, p, 4'b0001, 32'h80002345, 32'h00010000, 2'b01, 32'h80012345, 3);

      // Arithmetic edge cases on port 0, issued back to back
      req1(0, 0, 4'b0001, 32'hFFFFFFFF, 32'h00000001, 2'b10, 32'h0, 2);
      req1(0, 0, 4'b0010, 32'd5, 32'd6, 2'b10, 32'h0, 2);
      req1(0, 0, 4'b0010, 32'd6, 32'd5, 2'b01, 32'd1, 2);
      req1(0, 0, 4'b0011, 32'h1234, 32'h1, 2'b10, 32'h0, 4);

      // Shifts on port 1
      req1(0, 1, 4'b0101, 32'h00002000, 32'h1,  2'b01, 32'h00004000, 3);
      req1(0, 1, 4'b0110, 32'h00002000, 32'h21, 2'b01, 32'h00001000, 3);
      req1(0, 1, 4'b0101, 32'h80000000, 32'h1,  2'b01, 32'h00000000, 3);

      // Fixed priority: all ports at once, plus an ignored command on busy port 2
      t0 = cyc;
      for (int p = 0; p < NP; p++) begin
         expect_resp(0, p, t0 + 4 + p, 2'b01, 32'd2);
         drive(0, p, 4'b0001, 32'd1);
      end
      tick(1);
      set_chk(1, "busy_all", 4'hF, '0);
      for (int p = 0; p < NP; p++) drive(0, p, 4'b0000, 32'd1);
      tick(1);
      for (int p = 0; p < NP; p++) drive(0, p, 4'b0000, 32'd0);
      tick(1);
      drive(0, 2, 4'b0001, 32'd5);
      tick(1);
      set_chk(1, "busy_drain", 4'hE, '0);
      drive(0, 2, 4'b0000, 32'd7);
      tick(1);
      drive(0, 2, 4'b0000, 32'd0);
      tick(6);

      // Round-robin: port 0 alone moves the pointer to 1
      req1(1, 0, 4'b0001, 32'd3, 32'd4, 2'b01, 32'd7, 3);
      t0 = cyc;
      expect_resp(1, 1, t0 + 4, 2'b01, 32'd22);
      expect_resp(1, 0, t0 + 5, 2'b01, 32'd11);
      drive(1, 0, 4'b0001, 32'd10);
      drive(1, 1, 4'b0001, 32'd20);
      tick(1);
      drive(1, 0, 4'b0000, 32'd1);
      drive(1, 1, 4'b0000, 32'd2);
      tick(1);
      drive(1, 0, 4'b0000, 32'd0);
      drive(1, 1, 4'b0000, 32'd0);
      tick(5);
      // Port 1 alone leaves the pointer at 2
      req1(1, 1, 4'b0010, 32'd9, 32'd4, 2'b01, 32'd5, 3);
      t0 = cyc;
      for (int p = 0; p < NP; p++) begin
         expect_resp(1, p, t0 + rr_off[p], 2'b01, 32'(16 * p + 1));
         drive(1, p, 4'b0001, 32'(16 * p));
      end
      tick(1);
      set_chk(1, "busy_rr_all", '0, 4'hF);
      for (int p = 0; p < NP; p++) drive(1, p, 4'b0000, 32'd1);
      tick(1);
      for (int p = 0; p < NP; p++) drive(1, p, 4'b0000, 32'd0);
      tick(8);

      // Reset at the execute edge of a pending add
      drive(0, 3, 4'b0001, 32'd1);
      tick(1);
      drive(0, 3, 4'b0000, 32'd2);
      tick(1);
      drive(0, 3, 4'b0000, 32'd0);
      tick(1);
      reset = 1'b0;
      tick(1);
      reset = 1'b1;
      set_chk(2, "post_reset", '0, '0);
      tick(6);
      req1(0, 3, 4'b0001, 32'd1, 32'd2, 2'b01, 32'd3, 5);

      final_chk = 1'b1;
      @(negedge c_clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
